// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a producer and the UART serializer.
//   P_DATA     : byte to send, sampled by the serializer only on acceptance
//   Data_Valid : producer request; accepted when Busy is low
//   Busy       : serializer is mid-frame; requests are ignored, not queued
interface uart_tx_if;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       Busy;

   modport master (
      output P_DATA,
      output Data_Valid,
      input  Busy
   );

   modport slave (
      input  P_DATA,
      input  Data_Valid,
      output Busy
   );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART serializer, transmit-side counterpart of the oversampling
// receiver. Frame = start(0), 8 data bits LSB first, optional parity, stop(1).
// Every bit lasts Prescale clocks (0 behaves as 1).
// Ports:
//   CLK       : system clock, rising edge
//   RST       : synchronous active-low reset
//   bus       : slave side of uart_tx_if (P_DATA, Data_Valid, Busy)
//   PAR_EN    : 1 = append parity bit
//   PAR_TYP   : 0 = even, 1 = odd
//   Prescale  : clocks per bit
//   TX_OUT    : serial line, idle high, registered
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | driving start bit (0)
// DATA   | driving data_q[bit_cnt_q], LSB first
// PARITY | driving latched parity bit
// STOP   | driving stop bit (1), then back to IDLE
module uart_tx #(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   uart_tx_if.slave                  bus,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   output logic                      TX_OUT
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                    state_q,   state_d;
   logic [PRESCALE_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
   logic [PRESCALE_WIDTH-1:0] presc_q,   presc_d;
   logic [2:0]                bit_cnt_q, bit_cnt_d;
   logic [7:0]                data_q,    data_d;
   logic                      par_en_q,  par_en_d;
   logic                      par_bit_q, par_bit_d;
   logic                      tx_q,      tx_d;
   logic                      busy_q,    busy_d;
   logic                      bit_last;

   // presc_q is never 0, so presc_q-1 cannot wrap; a Prescale of all-ones
   // still compares correctly at full counter width.
   assign bit_last = (clk_cnt_q == (presc_q - PRESCALE_WIDTH'(1)));

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      presc_d   = presc_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      tx_d      = 1'b1;
      busy_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.Data_Valid) begin
               data_d    = bus.P_DATA;
               par_en_d  = PAR_EN;
               par_bit_d = (^bus.P_DATA) ^ PAR_TYP;
               presc_d   = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
               clk_cnt_d = '0;
               bit_cnt_d = 3'd0;
               state_d   = START;
            end
         end
         START: begin
            if (bit_last) begin
               clk_cnt_d = '0;
               state_d   = DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + PRESCALE_WIDTH'(1);
            end
         end
         DATA: begin
            if (bit_last) begin
               clk_cnt_d = '0;
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = 3'd0;
                  state_d   = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + PRESCALE_WIDTH'(1);
            end
         end
         PARITY: begin
            if (bit_last) begin
               clk_cnt_d = '0;
               state_d   = STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + PRESCALE_WIDTH'(1);
            end
         end
         STOP: begin
            // A request arriving on the last stop cycle is picked up in the
            // following IDLE cycle, giving one idle-high clock between frames.
            if (bit_last) begin
               clk_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               clk_cnt_d = clk_cnt_q + PRESCALE_WIDTH'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            clk_cnt_d = '0;
            bit_cnt_d = 3'd0;
         end
      endcase

      // Outputs are registered from the next state so the line changes in the
      // same cycle the state does.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_d[bit_cnt_d];
         PARITY:  tx_d = par_bit_d;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         presc_q   <= PRESCALE_WIDTH'(1);
         bit_cnt_q <= 3'd0;
         data_q    <= 8'h00;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         presc_q   <= presc_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign TX_OUT   = tx_q;
   assign bus.Busy = busy_q;

endmodule
